// File: rtl/gbmon_pkg.sv
// Shared constants for the Game Boy test monitor: serial-port register addresses,
// verdict strings, state encoding and the string-matcher helpers.
package gbmon_pkg;

  localparam logic [15:0] SB_ADDR      = 16'hFF01;
  localparam logic [15:0] SC_ADDR      = 16'hFF02;
  localparam int          SC_START_BIT = 7;

  localparam int PAT_LEN = 6;
  localparam int IDX_W   = 3;
  localparam logic [8*PAT_LEN-1:0] PASS_PAT = "Passed";
  localparam logic [8*PAT_LEN-1:0] FAIL_PAT = "Failed";

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    DONE_PASS    = 2'd1,
    DONE_FAIL    = 2'd2,
    DONE_TIMEOUT = 2'd3
  } gbmon_state_e;

  // Character idx of a pattern; the string literal stores its first char in the top byte.
  function automatic logic [7:0] pat_byte(input logic [8*PAT_LEN-1:0] pat,
                                          input logic [IDX_W-1:0]     idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (idx == IDX_W'(i)) b = pat[8*(PAT_LEN-1-i) +: 8];
    end
    return b;
  endfunction

  // A mismatching char may itself start a new attempt.
  function automatic logic [IDX_W-1:0] idx_next(input logic [8*PAT_LEN-1:0] pat,
                                                input logic [IDX_W-1:0]     idx,
                                                input logic [7:0]           c);
    logic [IDX_W-1:0] n;
    if (c == pat_byte(pat, idx)) begin
      n = (idx == IDX_W'(PAT_LEN-1)) ? '0 : idx + 1'b1;
    end else begin
      n = (c == pat_byte(pat, '0)) ? IDX_W'(1) : '0;
    end
    return n;
  endfunction

endpackage

// File: rtl/gbmon_fifo.sv
// Synchronous FIFO for captured serial characters; one cycle push-to-visible, no bypass.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module gbmon_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);
  // Head is forced to zero while empty so the output is defined straight out of reset.
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/gb_test_monitor.sv
// CPU bus snooper: captures SB/SC serial output, matches "Passed"/"Failed", runs a watchdog.
// Verdict flags appear one cycle after the completing edge; char FIFO drops (and flags) when full.
// GBMON_TRACE_EN adds simulation-only character and verdict printing.
module gb_test_monitor
  import gbmon_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_dout,
  input  logic             cpu_write,
  output logic [7:0]       ch_data,
  output logic             ch_valid,
  input  logic             ch_ready,
  output logic             overflow,
  output logic [CYC_W-1:0] cycles,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);

  localparam logic [CYC_W-1:0] WD_LAST = CYC_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  gbmon_state_e     state, state_nxt;
  logic [7:0]       sb_shadow;
  logic [IDX_W-1:0] pass_idx, fail_idx;
  logic             sb_wr, sc_start, push_ok, fifo_full, fifo_empty;
  logic             in_run, pass_done, fail_done, wd_expire;

  assign sb_wr    = cpu_write && (cpu_addr == SB_ADDR);
  assign sc_start = cpu_write && (cpu_addr == SC_ADDR) && cpu_dout[SC_START_BIT];
  assign in_run   = (state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    sb_shadow <= 8'h00;
    else if (sb_wr) sb_shadow <= cpu_dout;
  end

  gbmon_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (sc_start),
    .push_dat (sb_shadow),
    .push_ok  (push_ok),
    .pop      (ch_ready),
    .pop_dat  (ch_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ch_valid = !fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   overflow <= 1'b0;
    else if (sc_start && !push_ok) overflow <= 1'b1;
  end

  // Matchers see every started char, including ones the FIFO had to drop.
  assign pass_done = sc_start && (pass_idx == IDX_W'(PAT_LEN-1)) &&
                     (sb_shadow == pat_byte(PASS_PAT, pass_idx));
  assign fail_done = sc_start && (fail_idx == IDX_W'(PAT_LEN-1)) &&
                     (sb_shadow == pat_byte(FAIL_PAT, fail_idx));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pass_idx <= '0;
      fail_idx <= '0;
    end else if (sc_start && in_run) begin
      pass_idx <= idx_next(PASS_PAT, pass_idx, sb_shadow);
      fail_idx <= idx_next(FAIL_PAT, fail_idx, sb_shadow);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          cycles <= '0;
    else if (in_run && (cycles != '1))    cycles <= cycles + CYC_W'(1);
  end

  assign wd_expire = (MAX_CYCLES != 0) && (cycles == WD_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN) begin
      if (pass_done)      state_nxt = DONE_PASS;
      else if (fail_done) state_nxt = DONE_FAIL;
      else if (wd_expire) state_nxt = DONE_TIMEOUT;
    end
  end

  assign done    = (state != RUN);
  assign pass    = (state == DONE_PASS);
  assign fail    = (state == DONE_FAIL);
  assign timeout = (state == DONE_TIMEOUT);

`ifdef GBMON_TRACE_EN
  always @(posedge clk) begin
    if (resetn && push_ok) $write("%c", sb_shadow);
    if (resetn && (state == RUN) && (state_nxt != RUN))
      $display("\ngb_test_monitor: %s after %0d cycles", state_nxt.name(), cycles + CYC_W'(1));
  end
`endif

endmodule

// File: tb/tb_gb_test_monitor.sv
// Directed bench for gb_test_monitor: expected chars go into a queue, a negedge monitor
// pops and compares them whenever the DUT hands a char over.
module tb_gb_test_monitor;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_write = 1'b0;
  logic        ch_ready = 1'b0;
  logic        w_write = 1'b0;

  logic [7:0]  ch_data, w_ch_data;
  logic        ch_valid, overflow, done, pass, fail, timeout;
  logic        w_ch_valid, w_overflow, w_done, w_pass, w_fail, w_timeout;
  logic [31:0] cycles, w_cycles;

  int checks = 0;
  int errors = 0;
  int ecnt;
  int exp_cyc;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  gb_test_monitor #(.FIFO_DEPTH(4), .CYC_W(32), .MAX_CYCLES(2000)) dut (
    .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_write(cpu_write), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .overflow(overflow), .cycles(cycles), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout)
  );

  gb_test_monitor #(.FIFO_DEPTH(2), .CYC_W(32), .MAX_CYCLES(100)) dut_w (
    .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_write(w_write), .ch_data(w_ch_data), .ch_valid(w_ch_valid), .ch_ready(1'b1),
    .overflow(w_overflow), .cycles(w_cycles), .done(w_done), .pass(w_pass), .fail(w_fail),
    .timeout(w_timeout)
  );

  // Clock edges seen since reset release: the reference for the cycle counter.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) ecnt <= 0;
    else         ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a char is handed over at the next posedge when valid & ready.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && ch_valid && ch_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h, required no char", ch_data);
        end else begin
          chk("sb_char", 32'(ch_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench time limit");
  end

  // All tasks are entered and left at posedge+1.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_dout  = d;
    cpu_write = 1'b1;
    @(posedge clk); #1;
    cpu_write = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input bit stored, input bit pop_now);
    wr(16'hFF01, c);
    if (stored) exp_q.push_back(c);
    if (pop_now) ch_ready = 1'b1;
    wr(16'hFF02, 8'h81);
    if (pop_now) ch_ready = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    #2;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch_valid", 32'(ch_valid), 0);
    chk("rst_ch_data",  32'(ch_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_cycles",   cycles, 0);
    chk("rst_done",     32'({done, pass, fail, timeout}), 0);
    do_reset();

    // 1: single char, ignored writes, pop
    wr(16'hFF01, 8'h41);
    wr(16'hFF02, 8'h01);
    chk("t1_sc_bit7_clear", 32'(ch_valid), 0);
    wr(16'hFF03, 8'h81);
    chk("t1_other_addr", 32'(ch_valid), 0);
    exp_q.push_back(8'h41);
    wr(16'hFF02, 8'h81);
    chk("t1_valid", 32'(ch_valid), 1);
    chk("t1_data",  32'(ch_data), 32'h41);
    ch_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_popped", 32'(ch_valid), 0);

    // 2: "xPasPassed" with restarting matcher
    do_reset();
    send_str("xPasPasse");
    chk("t2_not_yet", 32'(done), 0);
    send_char("d", 1'b1, 1'b0);
    exp_cyc = ecnt;
    chk("t2_pass", 32'(pass), 1);
    chk("t2_done", 32'(done), 1);
    chk("t2_fail_timeout", 32'({fail, timeout}), 0);
    chk("t2_cycles", cycles, exp_cyc);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_cycles_frozen", cycles, exp_cyc);

    // 3: fail verdict is terminal
    do_reset();
    send_str("Failed");
    chk("t3_fail", 32'(fail), 1);
    chk("t3_done", 32'(done), 1);
    send_str("Passed");
    chk("t3_no_pass", 32'(pass), 0);
    chk("t3_still_fail", 32'(fail), 1);

    // 4: watchdog on the MAX_CYCLES=100 instance
    do_reset();
    for (int i = 0; i < 200 && ecnt < 99; i++) begin
      @(posedge clk); #1;
    end
    chk("t4_cycles_99", w_cycles, 99);
    chk("t4_no_timeout_yet", 32'(w_timeout), 0);
    @(posedge clk); #1;
    chk("t4_timeout", 32'(w_timeout), 1);
    chk("t4_done", 32'(w_done), 1);
    chk("t4_cycles_100", w_cycles, 100);
    chk("t4_pass_fail", 32'({w_pass, w_fail}), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_cycles_frozen", w_cycles, 100);

    // 5: overflow on a depth-4 FIFO, then push+pop while full
    do_reset();
    ch_ready = 1'b0;
    send_char("A", 1'b1, 1'b0);
    send_char("B", 1'b1, 1'b0);
    send_char("C", 1'b1, 1'b0);
    send_char("D", 1'b1, 1'b0);
    chk("t5_no_overflow", 32'(overflow), 0);
    chk("t5_head", 32'(ch_data), 32'h41);
    send_char("E", 1'b0, 1'b0);
    chk("t5_overflow", 32'(overflow), 1);
    send_char("F", 1'b1, 1'b1);
    chk("t5_head_after_swap", 32'(ch_data), 32'h42);
    ch_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_one_left", 32'(ch_valid), 1);
    @(posedge clk); #1;
    chk("t5_drained", 32'(ch_valid), 0);

    // 6: asynchronous reset in the middle of "Passed"
    do_reset();
    send_str("Pas");
    @(posedge clk); #1;
    chk("t6_cycles_before", cycles, ecnt);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_cycles", cycles, 0);
    chk("t6_async_flags", 32'({ch_valid, overflow, done, pass, fail, timeout}), 0);
    chk("t6_async_data", 32'(ch_data), 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h00);
    wr(16'hFF02, 8'h81);
    send_str("sed");
    chk("t6_no_pass", 32'(pass), 0);
    chk("t6_no_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_all_seen", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
